// File: rtl/reg_if_pkg.sv
// reg_if_pkg: shared constants and types for the UART register interface.
//   RSP_CMD / ERR_CMD : read-response header bytes (good / out-of-range)
//   WR_CMD            : write command byte seen by the command-receive path
//   N_REGS            : number of valid register addresses
//   rsp_state_t       : read-response transmitter FSM states
//   byte_t            : one UART byte
package reg_if_pkg;

    localparam logic [7:0]  RSP_CMD = 8'h02;
    localparam logic [7:0]  ERR_CMD = 8'hEE;
    localparam logic [7:0]  WR_CMD  = 8'h01;
    localparam int unsigned N_REGS  = 2;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} rsp_state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/tx_watchdog.sv
// tx_watchdog: per-byte down-counter that flags a stalled transmitter.
//   clk, rst : clock, async active-high reset
//   start_i  : reload the counter with TMO_CYC-1 (one cycle before waiting starts)
//   en_i     : count down this cycle (waiting, no completion seen)
//   exp_o    : counter has run out; never set when TMO_CYC == 0
module tx_watchdog #(
    parameter int unsigned TMO_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic en_i,
    output logic exp_o
);

    localparam int unsigned W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [W-1:0] LOAD = W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Loaded value TMO_CYC-1 reaches zero on the TMO_CYC-th waiting cycle.
    always_comb begin
        cnt_d = start_i ? LOAD : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= LOAD;
        else     cnt_q <= cnt_d;
    end

    assign exp_o = (TMO_CYC != 0) && (cnt_q == '0);

endmodule

// File: rtl/reg_rsp_tx.sv
// reg_rsp_tx: read-response transmitter; fetches one register and sends a 4-byte frame.
//   clk, rst     : clock, async active-high reset
//   rd_req       : read request pulse, rd_addr sampled with it
//   reg_rd_addr  : registered read address to the register array
//   reg_rd_data  : combinational read data from the register array
//   tx_wr        : UART TX load pulse; tx_data held until tx_done
//   tx_done      : UART TX byte-finished pulse
//   busy         : frame in progress
//   frame_done   : pulse in the first idle cycle after the 4th byte
//   rd_drop      : rd_req ignored because busy
//   tmo_err      : tx_done timeout, frame aborted
// Frame: header, address, data, XOR checksum of the first three.
module reg_rsp_tx #(
    parameter int unsigned N_REGS  = reg_if_pkg::N_REGS,
    parameter logic [7:0]  RSP_CMD = reg_if_pkg::RSP_CMD,
    parameter logic [7:0]  ERR_CMD = reg_if_pkg::ERR_CMD,
    parameter int unsigned TMO_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done,
    output logic       rd_drop,
    output logic       tmo_err
);

    import reg_if_pkg::*;

    rsp_state_t state_q, state_d;
    byte_t      addr_q, addr_d, dat_q, dat_d, tx_data_q, tx_data_d;
    logic       err_q, err_d, fd_q, wd_exp;
    logic [1:0] idx_q, idx_d;

    function automatic byte_t frame_byte(logic [1:0] i, logic e, byte_t a, byte_t d);
        byte_t h = e ? ERR_CMD : RSP_CMD;
        return (i == 2'd0) ? h : (i == 2'd1) ? a : (i == 2'd2) ? d : h ^ a ^ d;
    endfunction

    // tx_data is registered and loaded on entry to SEND, so it reads 0 after
    // reset and stays put through WAIT regardless of later state changes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        err_d     = err_q;
        dat_d     = dat_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: if (rd_req) begin
                state_d = FETCH;
                addr_d  = rd_addr;
                err_d   = 32'(rd_addr) >= N_REGS;
            end
            FETCH: begin
                dat_d     = err_q ? 8'h00 : reg_rd_data;
                idx_d     = 2'd0;
                tx_data_d = err_q ? ERR_CMD : RSP_CMD;
                state_d   = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (tx_done) begin
                if (idx_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    tx_data_d = frame_byte(idx_q + 2'd1, err_q, addr_q, dat_q);
                    state_d   = SEND;
                end
            end else if (wd_exp) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            fd_q      <= state_q == WAIT && tx_done && idx_q == 2'd3;
        end
    end

    tx_watchdog #(.TMO_CYC(TMO_CYC)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .start_i (state_q == SEND),
        .en_i    (state_q == WAIT && !tx_done),
        .exp_o   (wd_exp)
    );

    assign reg_rd_addr = addr_q;
    assign tx_wr       = state_q == SEND;
    assign tx_data     = tx_data_q;
    assign busy        = state_q != IDLE;
    assign frame_done  = fd_q;
    assign rd_drop     = rd_req && busy;
    // A tx_done arriving on the expiry cycle still completes the byte.
    assign tmo_err     = state_q == WAIT && !tx_done && wd_exp;

endmodule

// File: tb/tb_reg_rsp_tx.sv
// tb_reg_rsp_tx: scoreboard bench for reg_rsp_tx (main instance plus a short-timeout instance).
module tb_reg_rsp_tx;

    logic       clk = 1'b0, rst = 1'b1;
    logic       rd_req = 1'b0, tx_done = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] reg_rd_addr, reg_rd_data, tx_data;
    logic       tx_wr, busy, frame_done, rd_drop, tmo_err;

    logic       rd_req2 = 1'b0, tx_done2 = 1'b0;
    logic [7:0] rd_addr2 = 8'h00;
    logic [7:0] reg_rd_addr2, reg_rd_data2, tx_data2;
    logic       tx_wr2, busy2, frame_done2, rd_drop2, tmo_err2;

    logic [7:0] regs [2] = '{8'h5A, 8'h3C};
    logic [7:0] b2   [4] = '{8'h02, 8'h01, 8'h3C, 8'h3F};

    always #5 clk = ~clk;

    // Out-of-range addresses return junk that must never reach the frame.
    assign reg_rd_data  = (reg_rd_addr  < 8'd2) ? regs[reg_rd_addr[0]]  : 8'hA5;
    assign reg_rd_data2 = (reg_rd_addr2 < 8'd2) ? regs[reg_rd_addr2[0]] : 8'hA5;

    reg_rsp_tx dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .frame_done(frame_done), .rd_drop(rd_drop), .tmo_err(tmo_err)
    );

    reg_rsp_tx #(.TMO_CYC(16)) dut2 (
        .clk(clk), .rst(rst), .rd_req(rd_req2), .rd_addr(rd_addr2),
        .reg_rd_addr(reg_rd_addr2), .reg_rd_data(reg_rd_data2),
        .tx_wr(tx_wr2), .tx_data(tx_data2), .tx_done(tx_done2),
        .busy(busy2), .frame_done(frame_done2), .rd_drop(rd_drop2), .tmo_err(tmo_err2)
    );

    int tests = 0, fails = 0;
    int n_wr = 0, n_fd = 0, n_drop = 0, stab_err = 0, n_fd2 = 0, n_tmo2 = 0;
    int dly = 0;
    bit hold_chk = 1'b1;
    logic [7:0] exp_q [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every tx_wr pops the next expected byte.
    always @(negedge clk) begin
        if (tx_wr) begin
            n_wr++;
            if (exp_q.size() == 0) fail_now($sformatf("unexpected_tx_wr data %0h", tx_data));
            else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (frame_done) n_fd++;
        if (rd_drop) n_drop++;
        if (frame_done2) n_fd2++;
        if (tmo_err2) n_tmo2++;
    end

    // UART TX model for the main instance: tx_done 'dly' cycles after tx_wr.
    initial forever begin
        logic [7:0] d;
        @(negedge clk);
        if (tx_wr) begin
            d = tx_data;
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                if (hold_chk && tx_data !== d) stab_err++;
            end
            @(posedge clk); #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
        end
    end

    task automatic push4(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    endtask

    task automatic req(logic [7:0] a);
        @(posedge clk); #1 rd_req = 1'b1; rd_addr = a;
        @(posedge clk); #1 rd_req = 1'b0;
    endtask

    task automatic wait_wr(int target, int budget);
        int k = 0;
        while (n_wr < target && k < budget) begin @(negedge clk); k++; end
        if (n_wr < target) fail_now("wait_tx_wr_timeout");
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin @(negedge clk); k++; end
        if (busy || exp_q.size() != 0) fail_now("wait_idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, k, base, fd0, dr0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_wr", 32'(tx_wr), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_reg_rd_addr", 32'(reg_rd_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_tmo_err", 32'(tmo_err), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: good read of address 1, latency 2
        fd0 = n_fd;
        push4(8'h02, 8'h01, 8'h3C, 8'h3F);
        @(posedge clk); #1 rd_req = 1'b1; rd_addr = 8'h01;
        lat = 0;
        @(negedge clk);
        @(posedge clk); #1 rd_req = 1'b0;
        while (!tx_wr && lat < 10) begin @(negedge clk); lat++; end
        chk("first_tx_wr_latency", 32'(lat), 2);
        wait_idle(200);
        chk("t1_frame_done_count", 32'(n_fd - fd0), 1);
        chk("t1_queue_empty", 32'(exp_q.size()), 0);

        // 2: out-of-range address -> error frame, junk data ignored
        fd0 = n_fd;
        push4(8'hEE, 8'h07, 8'h00, 8'hE9);
        req(8'h07);
        wait_idle(200);
        chk("t2_frame_done_count", 32'(n_fd - fd0), 1);

        // 3: stray tx_done in IDLE, then slow transmitter
        base = n_wr;
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_tx_done_no_wr", 32'(n_wr - base), 0);
        chk("idle_tx_done_busy", 32'(busy), 0);
        dly = 50;
        stab_err = 0;
        fd0 = n_fd;
        push4(8'h02, 8'h00, 8'h5A, 8'h58);
        req(8'h00);
        wait_idle(400);
        chk("t3_tx_data_stable_errs", 32'(stab_err), 0);
        chk("t3_frame_done_count", 32'(n_fd - fd0), 1);

        // 5: rd_req during bytes 1 and 3 -> two drops, frame unchanged
        dly = 10;
        base = n_wr;
        fd0 = n_fd;
        dr0 = n_drop;
        push4(8'h02, 8'h01, 8'h3C, 8'h3F);
        req(8'h01);
        wait_wr(base + 2, 100);
        req(8'h00);
        wait_wr(base + 4, 100);
        req(8'h00);
        wait_idle(200);
        chk("t5_rd_drop_count", 32'(n_drop - dr0), 2);
        chk("t5_frame_done_count", 32'(n_fd - fd0), 1);
        chk("t5_tx_wr_count", 32'(n_wr - base), 4);

        // 6: reset in WAIT of byte 2
        dly = 20;
        hold_chk = 1'b0;
        base = n_wr;
        fd0 = n_fd;
        exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h3C);
        req(8'h01);
        wait_wr(base + 3, 100);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("mid_rst_tx_wr", 32'(tx_wr), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_reg_rd_addr", 32'(reg_rd_addr), 0);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        chk("mid_rst_tmo_err", 32'(tmo_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_no_more_tx_wr", 32'(n_wr - base), 3);
        chk("t6_no_frame_done", 32'(n_fd - fd0), 0);
        dly = 0;
        hold_chk = 1'b1;
        fd0 = n_fd;
        push4(8'h02, 8'h00, 8'h5A, 8'h58);
        req(8'h00);
        wait_idle(200);
        chk("t6_frame_done_after_rst", 32'(n_fd - fd0), 1);

        // 4: timeout on the TMO_CYC=16 instance, then recovery
        fd0 = n_fd2;
        @(posedge clk); #1 rd_req2 = 1'b1; rd_addr2 = 8'h00;
        @(posedge clk); #1 rd_req2 = 1'b0;
        k = 0;
        while (!tx_wr2 && k < 10) begin @(negedge clk); k++; end
        if (!tx_wr2) fail_now("t4_no_tx_wr");
        k = 0;
        do begin @(negedge clk); k++; end while (!tmo_err2 && k < 40);
        chk("t4_tmo_wait_cycles", 32'(k), 16);
        @(negedge clk);
        chk("t4_busy_after_tmo", 32'(busy2), 0);
        repeat (3) @(negedge clk);
        chk("t4_tmo_pulses", 32'(n_tmo2), 1);
        chk("t4_no_frame_done", 32'(n_fd2 - fd0), 0);
        @(posedge clk); #1 rd_req2 = 1'b1; rd_addr2 = 8'h01;
        @(posedge clk); #1 rd_req2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!tx_wr2 && k < 10) begin @(negedge clk); k++; end
            if (!tx_wr2) fail_now("t4_recovery_no_tx_wr");
            else chk("t4_recovery_byte", 32'(tx_data2), 32'(b2[i]));
            @(posedge clk); #1 tx_done2 = 1'b1;
            @(posedge clk); #1 tx_done2 = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("t4_recovery_frame_done", 32'(n_fd2 - fd0), 1);
        chk("t4_recovery_no_tmo", 32'(n_tmo2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
